sipm_hit_arbiter: RTL and testbench

Round-robin readout scheduler for the scintillator SiPM channel array. It watches the per-channel latched hit outputs, which are the 2-bit signal height and the timestamp, and grants one pending channel at a time. It serialises the granted hit into a fixed 4-word packet on the shared 16-bit FIFO write port, then pulses that channel's latch clear. It sits between the SiPM_reader1 instances and the data FIFO, and owns both the FIFO write side and the `clear_SiPM` vector.

---
 rtl/sipm_hit_arbiter.sv | 167 ++++++++++++++++
 tb/tb_sipm_hit_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sipm_hit_arbiter.sv
// Round-robin readout arbiter: grants one pending SiPM channel at a time and writes its hit as a fixed packet to the FIFO.
// Optional macro SIPM_ARB_SEQNUM_EN appends a 16-bit packet sequence word (W4).
module sipm_hit_arbiter #(
    parameter int SIPM_NUMBER   = 20,
    parameter int TIMESTAMP_LEN = 40
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [SIPM_NUMBER*TIMESTAMP_LEN-1:0]   timestamp_input,
    input  logic [2*SIPM_NUMBER-1:0]               signal_height_input,
    input  logic                                   start_daq,
    input  logic                                   full,
    output logic [15:0]                            data_out,
    output logic                                   wr_en,
    output logic [SIPM_NUMBER-1:0]                 clear_SiPM,
    output logic                                   busy,
    output logic [2:0]                             state_dbg
);
    localparam int IDX_W = $clog2(SIPM_NUMBER);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        W0    = 3'd1,
        W1    = 3'd2,
        W2    = 3'd3,
        W3    = 3'd4,
`ifdef SIPM_ARB_SEQNUM_EN
        W4    = 3'd5,
`endif
        CLEAR = 3'd6
    } state_t;

    // Handshake: in a write state wr_en = !full and data_out carries the word;
    // the word is accepted (state advances) only on a cycle where wr_en = 1.
    state_t                     state;
    logic [IDX_W-1:0]           ptr;
    logic [IDX_W-1:0]           grant_idx;
    logic                       grant_found;
    logic [SIPM_NUMBER-1:0]     pending;
    logic                       mask_valid;
    logic [4:0]                 snap_ch;
    logic [1:0]                 snap_h;
    logic [TIMESTAMP_LEN-1:0]   snap_ts;
    logic [1:0]                 gnt_h;
    logic [TIMESTAMP_LEN-1:0]   gnt_ts;
    logic [15:0]                word;
    logic [15:0]                ts_hi;
    logic                       in_word;
`ifdef SIPM_ARB_SEQNUM_EN
    logic [15:0]                seq_cnt;
`endif

    // The just-cleared channel is hidden for one IDLE cycle while its latch clear propagates.
    always_comb begin
        pending = '0;
        for (int i = 0; i < SIPM_NUMBER; i++) begin
            pending[i] = (signal_height_input[2*i +: 2] != 2'b00) && start_daq &&
                         !(mask_valid && (snap_ch == 5'(i)));
        end
    end

    always_comb begin
        logic [IDX_W:0] idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int k = 0; k < SIPM_NUMBER; k++) begin
            idx = {1'b0, ptr} + (IDX_W+1)'(k);
            if (idx >= (IDX_W+1)'(SIPM_NUMBER)) begin
                idx = idx - (IDX_W+1)'(SIPM_NUMBER);
            end
            if (!grant_found && pending[idx[IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = idx[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        gnt_h  = '0;
        gnt_ts = '0;
        for (int i = 0; i < SIPM_NUMBER; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                gnt_h  = signal_height_input[2*i +: 2];
                gnt_ts = timestamp_input[i*TIMESTAMP_LEN +: TIMESTAMP_LEN];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ptr        <= '0;
            mask_valid <= 1'b0;
            snap_ch    <= '0;
            snap_h     <= '0;
            snap_ts    <= '0;
`ifdef SIPM_ARB_SEQNUM_EN
            seq_cnt    <= '0;
`endif
        end else begin
            mask_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        snap_ch <= 5'(grant_idx);
                        snap_h  <= gnt_h;
                        snap_ts <= gnt_ts;
                        ptr     <= (grant_idx == IDX_W'(SIPM_NUMBER - 1)) ? '0
                                                                          : grant_idx + IDX_W'(1);
                        state   <= W0;
                    end
                end
                W0: if (!full) state <= W1;
                W1: if (!full) state <= W2;
                W2: if (!full) state <= W3;
`ifdef SIPM_ARB_SEQNUM_EN
                W3: if (!full) state <= W4;
                W4: begin
                    if (!full) begin
                        seq_cnt <= seq_cnt + 16'd1;
                        state   <= CLEAR;
                    end
                end
`else
                W3: if (!full) state <= CLEAR;
`endif
                CLEAR: begin
                    mask_valid <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Packet words come only from the snapshot, so late changes on the channel inputs are ignored.
    always_comb begin
        ts_hi = '0;
        ts_hi[TIMESTAMP_LEN-33:0] = snap_ts[TIMESTAMP_LEN-1:32];
        word    = '0;
        in_word = 1'b1;
        case (state)
            W0:      word = {4'hA, 5'b0, snap_h, snap_ch};
            W1:      word = ts_hi;
            W2:      word = snap_ts[31:16];
            W3:      word = snap_ts[15:0];
`ifdef SIPM_ARB_SEQNUM_EN
            W4:      word = seq_cnt;
`endif
            default: in_word = 1'b0;
        endcase
        wr_en    = in_word && !full;
        data_out = word;
    end

    always_comb begin
        clear_SiPM = '0;
        for (int i = 0; i < SIPM_NUMBER; i++) begin
            clear_SiPM[i] = (state == CLEAR) && (snap_ch == 5'(i));
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_sipm_hit_arbiter.sv
// Bench for sipm_hit_arbiter: latch model on the channel inputs, expected-word and expected-clear queues.
// Define SIPM_ARB_SEQNUM_EN for both files to exercise the 5-word packet build.
module tb_sipm_hit_arbiter;
    localparam int N  = 20;
    localparam int TL = 40;
`ifdef SIPM_ARB_SEQNUM_EN
    localparam int PW = 5;
`else
    localparam int PW = 4;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [N*TL-1:0]     timestamp_input;
    logic [2*N-1:0]      signal_height_input;
    logic                start_daq;
    logic                full;
    logic [15:0]         data_out;
    logic                wr_en;
    logic [N-1:0]        clear_SiPM;
    logic                busy;
    logic [2:0]          state_dbg;

    logic [1:0]          lat_h  [N];
    logic [TL-1:0]       lat_ts [N];

    logic [15:0]         exp_q[$];
    logic [N-1:0]        exp_clr_q[$];
    logic [15:0]         seq_model;
    logic [15:0]         pop_w;
    logic [N-1:0]        pop_c;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int clr_cnt  = 0;
    int last_clr_cyc = 0;

    sipm_hit_arbiter #(.SIPM_NUMBER(N), .TIMESTAMP_LEN(TL)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .timestamp_input     (timestamp_input),
        .signal_height_input (signal_height_input),
        .start_daq           (start_daq),
        .full                (full),
        .data_out            (data_out),
        .wr_en               (wr_en),
        .clear_SiPM          (clear_SiPM),
        .busy                (busy),
        .state_dbg           (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            signal_height_input[2*i +: 2] = lat_h[i];
            timestamp_input[i*TL +: TL]   = lat_ts[i];
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // SiPM latch model: a clear pulse empties the channel's height.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (clear_SiPM[i]) lat_h[i] = 2'b00;
        end
    end

    // scoreboard monitor
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            if (full) check_val("wr_en_while_full", 64'(wr_en), 64'd0);
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    check_val("spurious_word", 64'(exp_q.size()), 64'd1);
                end else begin
                    pop_w = exp_q.pop_front();
                    check_val("word", 64'(data_out), 64'(pop_w));
                end
            end
            if (clear_SiPM != '0) begin
                clr_cnt++;
                last_clr_cyc = cyc;
                if (exp_clr_q.size() == 0) begin
                    check_val("spurious_clear", 64'(exp_clr_q.size()), 64'd1);
                end else begin
                    pop_c = exp_clr_q.pop_front();
                    check_val("clear", 64'(clear_SiPM), 64'(pop_c));
                end
            end
        end
    end

    // driver tasks
    task automatic set_hit(input int ch, input logic [1:0] h, input logic [TL-1:0] ts);
        lat_h[ch]  = h;
        lat_ts[ch] = ts;
    endtask

    task automatic set_rand_hit(input int ch);
        set_hit(ch, 2'($urandom_range(1, 3)), TL'({$urandom(), $urandom()}));
    endtask

    task automatic push_pkt(input int ch);
        logic [TL-1:0] t;
        logic [15:0]   w1;
        logic [N-1:0]  oh;
        t  = lat_ts[ch];
        w1 = '0;
        w1[TL-33:0] = t[TL-1:32];
        exp_q.push_back({4'hA, 5'b0, lat_h[ch], 5'(ch)});
        exp_q.push_back(w1);
        exp_q.push_back(t[31:16]);
        exp_q.push_back(t[15:0]);
`ifdef SIPM_ARB_SEQNUM_EN
        exp_q.push_back(seq_model);
        seq_model = seq_model + 16'd1;
`endif
        oh = '0;
        oh[ch] = 1'b1;
        exp_clr_q.push_back(oh);
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        exp_q.delete();
        exp_clr_q.delete();
        seq_model = 16'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic wait_wr(output int n);
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!wr_en && n < 50);
        check_val("wait_wr", 64'(wr_en), 64'd1);
    endtask

    task automatic wait_clr(output int n);
        int start;
        start = clr_cnt;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (clr_cnt == start && n < 100);
        check_val("wait_clr", 64'(clr_cnt != start), 64'd1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_clr_q.size() != 0) && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        check_val("drain", 64'(exp_q.size() + exp_clr_q.size()), 64'd0);
    endtask

    task automatic check_idle(input string tag, input int cycles);
        repeat (cycles) begin
            @(negedge clk); #1;
            check_val(tag, {data_out, wr_en, clear_SiPM, busy, state_dbg}, 64'd0);
        end
    endtask

    initial begin
        int n;
        int c0;
        logic [15:0] w1_exp;
        rst       = 1'b0;
        full      = 1'b0;
        start_daq = 1'b1;
        seq_model = 16'd0;
        for (int i = 0; i < N; i++) begin
            lat_h[i]  = 2'b00;
            lat_ts[i] = '0;
        end

        reset_dut();
        check_idle("idle_after_reset", 20);

        // single hit with fixed values
        @(posedge clk); #1;
        set_hit(3, 2'b10, 40'h12_3456_789A);
        exp_q.push_back(16'hA043);
        exp_q.push_back(16'h0012);
        exp_q.push_back(16'h3456);
        exp_q.push_back(16'h789A);
`ifdef SIPM_ARB_SEQNUM_EN
        exp_q.push_back(16'h0000);
        seq_model = seq_model + 16'd1;
`endif
        exp_clr_q.push_back(20'h00008);
        wait_wr(n);
        check_val("w0_latency", 64'(n), 64'd2);
        c0 = cyc;
        set_hit(3, 2'b01, 40'hFF_FFFF_FFFF);
        wait_clr(n);
        check_val("clr_latency", 64'(last_clr_cyc - c0), 64'(PW));
        check_idle("idle_after_single", 5);

        // round robin from ptr = 0
        reset_dut();
        set_rand_hit(0);
        set_rand_hit(5);
        set_rand_hit(19);
        push_pkt(0);
        push_pkt(5);
        push_pkt(19);
        wait_clr(n);
        @(posedge clk); #1;
        set_rand_hit(0);
        push_pkt(0);
        wait_drain();
        check_idle("idle_after_rr", 3);

        // backpressure on W1
        @(posedge clk); #1;
        set_rand_hit(10);
        push_pkt(10);
        wait_wr(n);
        check_val("bp_w0_latency", 64'(n), 64'd2);
        c0 = cyc;
        w1_exp = exp_q[0];
        @(posedge clk); #1 full = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            check_val("stall_wr_en", 64'(wr_en), 64'd0);
            check_val("stall_data", 64'(data_out), 64'(w1_exp));
            check_val("stall_busy", 64'(busy), 64'd1);
        end
        @(posedge clk); #1 full = 1'b0;
        wait_clr(n);
        check_val("bp_clr_latency", 64'(last_clr_cyc - c0), 64'(PW + 3));

        // start_daq dropped mid-packet
        @(posedge clk); #1;
        set_rand_hit(2);
        set_rand_hit(7);
        push_pkt(2);
        wait_wr(n);
        @(posedge clk); #1 start_daq = 1'b0;
        wait_clr(n);
        check_idle("idle_daq_off", 10);
        push_pkt(7);
        start_daq = 1'b1;
        wait_drain();

        // reset in W2
        @(posedge clk); #1;
        set_rand_hit(14);
        push_pkt(14);
        wait_wr(n);
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b0;
        #1;
        check_val("async_reset_outs", {data_out, wr_en, clear_SiPM, busy}, 64'd0);
        check_val("async_reset_state", 64'(state_dbg), 64'd0);
        exp_q.delete();
        exp_clr_q.delete();
        seq_model = 16'd0;
        push_pkt(14);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        wait_drain();
        check_idle("idle_end", 5);

        check_val("exp_q_empty", 64'(exp_q.size()), 64'd0);
        check_val("clr_q_empty", 64'(exp_clr_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
